// File: rtl/uart_rx_8n1.sv
// rtl/uart_rx_8n1.sv - 8N1 UART receiver with start-glitch rejection and break hold-off
`timescale 1ns/1ps

module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       ready,
    output logic       frame_err,
    output logic       busy
);

    localparam int N  = CLKS_PER_BIT;
    localparam int H  = N / 2;
    localparam int CW = $clog2(N);

    localparam logic [CW-1:0] LAST_N = CW'(N - 1);
    localparam logic [CW-1:0] LAST_H = CW'(H - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          ready_q, ready_d;
    logic          frame_err_q, frame_err_d;
    logic          rx_s;

    assign rx_s = sync2_q;

    always_comb begin
        sync1_d = rx;
        sync2_d = sync1_q;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        data_d      = data_q;
        ready_d     = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                // Mid-bit re-check rejects line glitches shorter than half a bit
                if (cnt_q == LAST_H) begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == LAST_N) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == LAST_N) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                // Held-low line is reported once; wait for idle before rearming
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data      = data_q;
    assign ready     = ready_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb/tb_uart_rx_8n1.sv - scoreboard bench for uart_rx_8n1 at 16 and 5 clocks per bit
`timescale 1ns/1ps

module tb_uart_rx_8n1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_a, rx_b;
    logic [7:0] data_a, data_b;
    logic       ready_a, ready_b;
    logic       frame_err_a, frame_err_b;
    logic       busy_a, busy_b;

    uart_rx_8n1 #(.CLKS_PER_BIT(16)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx_a),
        .data      (data_a),
        .ready     (ready_a),
        .frame_err (frame_err_a),
        .busy      (busy_a)
    );

    uart_rx_8n1 #(.CLKS_PER_BIT(5)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx_b),
        .data      (data_b),
        .ready     (ready_b),
        .frame_err (frame_err_b),
        .busy      (busy_b)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  b;
        int unsigned t;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ferr_a   = 0;
    int   ferr_b   = 0;
    bit   busy_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Caller must be sitting on a negedge; the frame starts on that edge.
    task automatic send(input bit sel, input logic [7:0] b, input bit stop_v, input int n);
        logic [9:0] frm;
        exp_t       e;
        frm = {stop_v, b, 1'b0};
        if (stop_v) begin
            e.b = b;
            e.t = cyc + 1 + 2 + n / 2 + 9 * n;
            if (sel) q_b.push_back(e);
            else     q_a.push_back(e);
        end
        for (int i = 0; i < 10; i++) begin
            if (sel) rx_b = frm[i];
            else     rx_a = frm[i];
            repeat (n) @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        if (ready_a === 1'b1) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_ready", 32'd1, 32'd0);
            end else begin
                ea = q_a.pop_front();
                check("a_data", {24'd0, data_a}, {24'd0, ea.b});
                check("a_ready_cycle", cyc, ea.t);
            end
        end
        if (ready_b === 1'b1) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_ready", 32'd1, 32'd0);
            end else begin
                eb = q_b.pop_front();
                check("b_data", {24'd0, data_b}, {24'd0, eb.b});
                check("b_ready_cycle", cyc, eb.t);
            end
        end
        if (frame_err_a === 1'b1) ferr_a++;
        if (frame_err_b === 1'b1) ferr_b++;
        if (ready_a | frame_err_a) check("a_strobe_excl", {31'd0, ready_a & frame_err_a}, 32'd0);
        if (ready_b | frame_err_b) check("b_strobe_excl", {31'd0, ready_b & frame_err_b}, 32'd0);
    end

    initial begin
        rst_n = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data_a",  {24'd0, data_a}, 32'h00);
        check("rst_ready_a", {31'd0, ready_a}, 32'd0);
        check("rst_ferr_a",  {31'd0, frame_err_a}, 32'd0);
        check("rst_busy_a",  {31'd0, busy_a}, 32'd0);
        check("rst_data_b",  {24'd0, data_b}, 32'h00);
        check("rst_busy_b",  {31'd0, busy_b}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send(1'b0, 8'hAA, 1'b1, 16);
        repeat (30) @(negedge clk);
        check("single_drained", q_a.size(), 32'd0);
        check("single_data", {24'd0, data_a}, 32'hAA);

        send(1'b0, 8'hAA, 1'b1, 16);
        send(1'b0, 8'hAA, 1'b1, 16);
        send(1'b0, 8'h01, 1'b1, 16);
        repeat (30) @(negedge clk);
        check("b2b_drained", q_a.size(), 32'd0);
        check("b2b_data", {24'd0, data_a}, 32'h01);

        rx_a = 1'b0;
        busy_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy_a) busy_seen = 1'b1;
        end
        rx_a = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
        check("glitch_idle", {31'd0, busy_a}, 32'd0);
        check("glitch_data", {24'd0, data_a}, 32'h01);
        check("glitch_no_ferr", ferr_a, 32'd0);

        send(1'b0, 8'h55, 1'b0, 16);
        repeat (100) @(negedge clk);
        check("break_busy", {31'd0, busy_a}, 32'd1);
        check("break_ferr_once", ferr_a, 32'd1);
        check("break_data", {24'd0, data_a}, 32'h01);
        rx_a = 1'b1;
        repeat (10) @(negedge clk);
        check("break_released", {31'd0, busy_a}, 32'd0);
        send(1'b0, 8'h3C, 1'b1, 16);
        repeat (30) @(negedge clk);
        check("after_break_drained", q_a.size(), 32'd0);
        check("after_break_data", {24'd0, data_a}, 32'h3C);

        rx_a = 1'b0;
        repeat (16) @(negedge clk);
        rx_a = 1'b1;
        repeat (4 * 16 + 8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_data",  {24'd0, data_a}, 32'h00);
        check("abort_busy",  {31'd0, busy_a}, 32'd0);
        check("abort_ready", {31'd0, ready_a}, 32'd0);
        check("abort_ferr",  {31'd0, frame_err_a}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("abort_idle", {31'd0, busy_a}, 32'd0);
        check("abort_data_held", {24'd0, data_a}, 32'h00);
        send(1'b0, 8'h81, 1'b1, 16);
        repeat (30) @(negedge clk);
        check("post_abort_drained", q_a.size(), 32'd0);
        check("post_abort_data", {24'd0, data_a}, 32'h81);

        send(1'b1, 8'hC3, 1'b1, 5);
        repeat (20) @(negedge clk);
        check("odd_n_drained", q_b.size(), 32'd0);
        check("odd_n_data", {24'd0, data_b}, 32'hC3);

        check("total_ferr_a", ferr_a, 32'd1);
        check("total_ferr_b", ferr_b, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_8n1.md
UART_RX_8N1 -- requirements
Module: uart_rx_8n1

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, giving clk cycles per UART bit; legal values are integers >= 4.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset; asynchronous, active-low.
REQ-004 SHALL have port rx, input, 1, the asynchronous serial line; idle level is 1.
REQ-005 SHALL have port data, output, 8, the last correctly received byte.
REQ-006 SHALL have port ready, output, 1, a one-cycle strobe meaning data holds a new valid byte; it drives the downstream byte-assembler ready input directly.
REQ-007 SHALL have port frame_err, output, 1, a one-cycle strobe meaning the stop bit was sampled as 0.
REQ-008 SHALL have port busy, output, 1, which is high in every state except IDLE.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer, reset to 1; all decisions use the synchronized value rx_s.
REQ-010 SHALL implement the states IDLE, START, DATA, STOP and BREAK.
REQ-011 SHALL define N = CLKS_PER_BIT and H = N/2 using integer division.
REQ-012 IDLE: when rx_s = 0, SHALL clear the bit counter and cycle counter and go to START.
REQ-013 START: on the H-th cycle, SHALL re-sample rx_s; if 1 (glitch), go to IDLE with no strobe; if 0, clear the counter and go to DATA.
REQ-014 DATA: on every N-th cycle, SHALL sample rx_s into the shift register, LSB first; after the 8th sample, go to STOP.
REQ-015 STOP: on the N-th cycle, SHALL sample rx_s; if 1, load data from the shift register, pulse ready for exactly 1 cycle and go to IDLE.
REQ-016 STOP: if the sample is 0, SHALL pulse frame_err for exactly 1 cycle, leave data unchanged, assert no ready and go to BREAK.
REQ-017 BREAK: SHALL wait until rx_s = 1, then go to IDLE, so that a held-low line is reported once, not repeatedly.
REQ-018 SHALL assert ready exactly 2 + H + 9*N clk cycles after the first rising edge at which rx is sampled 0 (REQ-009, REQ-013 to REQ-015).
REQ-019 In STOP, SHALL ignore rx_s on every cycle except the N-th one.
REQ-020 SHALL be back in IDLE on the cycle ready is high, so a start bit that immediately follows the stop bit is accepted; back-to-back frames lose no byte.
REQ-021 SHALL never have ready and frame_err high in the same cycle.
REQ-022 SHALL leave data stable between ready strobes; the downstream block samples data only when ready = 1.
REQ-023 SHALL keep all counters wide enough for N-1 with no wrap inside a bit period; the bit counter runs 0..7 and is cleared on entry to DATA.

Reset
REQ-024 While rst_n = 0, SHALL hold data = 8'h00, ready = 0, frame_err = 0, busy = 0, state = IDLE, counters = 0 and synchronizer flops = 1.
REQ-025 SHALL abort any frame in progress on reset assertion, emitting no strobe, and SHALL deliver no partial byte after release.
REQ-026 After rst_n rises, SHALL first react to rx only once the synchronizer has seen rx = 0; a line that is already low at release is treated as a start bit.

Verification (N = 16, 8N1 frames driven LSB first, 16 clk cycles per bit)
REQ-027 Single frame 0xAA, then idle high -> exactly one ready pulse at the REQ-018 cycle (2+8+144 = 154 cycles after the start edge), data = 8'hAA, frame_err never high.
REQ-028 Back-to-back frames 0xAA, 0xAA, 0x01 with no idle gap -> three ready pulses spaced 160 cycles apart; data = 0xAA, 0xAA, 0x01 respectively.
REQ-029 rx low for 4 cycles, then high -> busy pulses high, then returns to IDLE; no ready, no frame_err, data unchanged.
REQ-030 Frame 0x55 with stop bit = 0, rx held low for 100 further cycles, then high, then a clean frame 0x3C -> one frame_err pulse, no ready for 0x55, busy stays high until rx goes high, then ready with data = 0x3C.
REQ-031 rst_n pulsed low during data bit 4 of frame 0xFF, then a clean frame 0x81 -> outputs take reset values immediately, no strobe for the aborted frame, then ready with data = 0x81.
REQ-032 Parameter CLKS_PER_BIT = 5 (odd, H = 2), frame 0xC3 -> ready at cycle 2+2+45 = 49 after the start edge, data = 0xC3.
